dot_product_engine: RTL
=======================

// Module: dot_product_engine
// PURPOSE
//  Matrix-vector dot-product sequencer in the dotProduct datapath. On start, reads
//  operand matrix A (row-major) and vector B from two registered-read operand memories,
//  multiply-accumulates each A row against B, and writes one result per row into the
//  result memory over its write port (write_en/write_address/data_in). Unsigned arithmetic.
// PARAMETERS
//  DATA_WIDTH  8   operand element width (A and B memories)
//  RES_WIDTH   8   result word width written to result memory
//  ADDR_WIDTH  4   address width of all three memories
//  VEC_LEN     4   elements per row / length of B; >=2
//  NUM_ROWS    4   rows of A = results written; NUM_ROWS*VEC_LEN <= 2**ADDR_WIDTH
//  SATURATE    0   0: truncate result to low RES_WIDTH bits; 1: clamp to all-ones
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           synchronous active-low reset
//  start       in   1           request a run; sampled only in IDLE
//  busy        out  1           high in every state except IDLE
//  done        out  1           one-cycle pulse, run complete
//  a_rd_en     out  1           A memory read enable
//  a_rd_addr   out  ADDR_WIDTH  A address = row*VEC_LEN + k
//  a_rd_data   in   DATA_WIDTH  A data, valid 1 cycle after a_rd_en
//  b_rd_en     out  1           B memory read enable
//  b_rd_addr   out  ADDR_WIDTH  B address = k
//  b_rd_data   in   DATA_WIDTH  B data, valid 1 cycle after b_rd_en
//  res_wr_en   out  1           result memory write enable
//  res_wr_addr out  ADDR_WIDTH  result address = row
//  res_wr_data out  RES_WIDTH   result word
// BEHAVIOUR
//  - Reset: rst_n sampled low at posedge -> state IDLE, row/k/acc/valid-pipe = 0. All
//    outputs are decodes of registered state, so every output is 0 from that edge on.
//    Reset mid-run aborts immediately; no further reads/writes, no done.
//  - Operand memories have exactly 1-cycle read latency; data captured unconditionally
//    on the cycle after a read (1-bit registered valid flag tracks it).
//  - ACC_W = 2*DATA_WIDTH + $clog2(VEC_LEN); product and sum never overflow internally.
//  - FSM:
//    IDLE : busy=0. start=1 -> RUN, row=0, k=0, acc=0. start otherwise ignored.
//    RUN  : a_rd_en=b_rd_en=1, addresses per PORTS. If valid flag set, acc += a*b.
//           k==VEC_LEN-1 -> ACC, else k++.
//    ACC  : no reads; acc += product of last read (final term of the row) -> WR.
//    WR   : res_wr_en=1, res_wr_addr=row, res_wr_data=acc truncated or clamped
//           (SATURATE=1: acc > 2**RES_WIDTH-1 -> all ones). acc<=0, k<=0.
//           row==NUM_ROWS-1 -> DONE, else row++ -> RUN.
//    DONE : done=1, busy=1, one cycle -> IDLE.
//  - Timing: VEC_LEN+2 cycles per row. With start accepted at edge 0, RUN begins
//    cycle 1, done is high in cycle NUM_ROWS*(VEC_LEN+2)+1 (25 at defaults).
//  - Exactly one write per row, addresses 0..NUM_ROWS-1 ascending, no other writes.
//  - start high while busy (including DONE) is ignored; no queuing. start high in the
//    IDLE cycle after DONE starts a new run (back-to-back allowed).
//  - First RUN cycle of every row accumulates nothing (valid flag clear after ACC/WR).
//  - Read/write enables never overlap: reads only in RUN, write only in WR.
// TESTING
//  1 A rows all {1,2,3,4}, B={1,1,1,1}, pulse start -> writes 10 to addr 0..3 in
//    cycles 6,12,18,24; done high only in cycle 25; busy high cycles 1..25.
//  2 A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, B={1,0,0,1} ->
//    results 5,13,21,29 at addr 0..3; a_rd_addr sequence 0..15 each once.
//  3 A, B all 255: SATURATE=0 -> every result 0x04 (260100=0x3F804);
//    SATURATE=1 -> every result 0xFF.
//  4 start held high for 40 cycles -> first run completes with exactly 4 writes and
//    one done at cycle 25; second run starts cycle 26 (IDLE accept), done at cycle 51.
//  5 rst_n low for 1 cycle during row 2 RUN -> all outputs 0 next cycle, no writes to
//    addr 2/3, no done; new start then yields the full correct result set of test 1.
//  6 Random A/B (100 runs, SATURATE 0 and 1) vs reference model of result memory
//    contents; assert no write outside WR, reads only in RUN, done width 1.

Source files
------------

// File: rtl/dot_product_engine.sv
// Matrix-vector dot-product sequencer: streams A rows and B from
// registered-read memories, MACs each row, writes one word per row.
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int VEC_LEN    = 4,
  parameter int NUM_ROWS   = 4,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  a_rd_en,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic [RES_WIDTH-1:0]  res_wr_data
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(VEC_LEN);

  localparam logic [ADDR_WIDTH-1:0] K_LAST =
    ADDR_WIDTH'(VEC_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST =
    ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] VL =
    ADDR_WIDTH'(VEC_LEN);
  localparam logic [ACC_W-1:0] RES_MAX =
    ACC_W'((64'd1 << RES_WIDTH) - 64'd1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ACC,
    WR,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] k;
  logic [ACC_W-1:0]      acc;
  logic                  rd_vld;
  logic [PROD_W-1:0]     prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [RES_WIDTH-1:0]  res_word;

  assign prod     = PROD_W'(a_rd_data) * PROD_W'(b_rd_data);
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    res_word = RES_WIDTH'(acc);
    if (SATURATE != 0 && acc > RES_MAX)
      res_word = '1;
  end

  // Outputs are pure decodes of the registered state and counters.
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign a_rd_en     = (state == RUN);
  assign b_rd_en     = (state == RUN);
  assign res_wr_en   = (state == WR);
  assign a_rd_addr   = a_rd_en ? row * VL + k : '0;
  assign b_rd_addr   = b_rd_en ? k : '0;
  assign res_wr_addr = res_wr_en ? row : '0;
  assign res_wr_data = res_wr_en ? res_word : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      k      <= '0;
      acc    <= '0;
      rd_vld <= 1'b0;
    end else begin
      // Read data lands one cycle after a RUN cycle.
      rd_vld <= (state == RUN);
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            row   <= '0;
            k     <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (rd_vld)
            acc <= acc + prod_ext;
          if (k == K_LAST)
            state <= ACC;
          else
            k <= k + 1'b1;
        end
        ACC: begin
          acc   <= acc + prod_ext;
          state <= WR;
        end
        WR: begin
          acc <= '0;
          k   <= '0;
          if (row == ROW_LAST) begin
            state <= DONE;
          end else begin
            row   <= row + 1'b1;
            state <= RUN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
